// File: rtl/ram_rd_pkg.sv
// Shared types for the RAM stream reader: FSM state encoding and stall counter width.
package ram_rd_pkg;

    typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

    localparam int unsigned STALL_W = 16;

endpackage

// File: rtl/ram_stream_reader.sv
// Read-side engine: walks (base, len) over an async-read RAM and emits a valid/ready stream.
// Optional stall counter is built only when RAM_STREAM_READER_STALL_CNT_EN is defined.
module ram_stream_reader
    import ram_rd_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned WORDS = 256,
    localparam int unsigned AW   = $clog2(WORDS),
    localparam int unsigned LW   = AW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [AW-1:0]      cmd_base,
    input  logic [LW-1:0]      cmd_len,
    output logic [AW-1:0]      rd_addr,
    input  logic [DW-1:0]      rd_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DW-1:0]      m_data,
    output logic               m_last,
    output logic               done,
    output logic [STALL_W-1:0] stall_cnt
);

    if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_words
        $error("ram_stream_reader: WORDS must be a power of two and at least 2");
    end

    rd_state_t     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] remain_q, remain_d;
    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_last_q, m_last_d;
    logic          done_q, done_d;
    logic          cmd_hs;
    logic          slot_free;

    assign cmd_ready = (state_q == RD_IDLE);
    assign cmd_hs    = cmd_valid && cmd_ready;
    // Output register can take a new beat when empty or being drained this cycle.
    assign slot_free = !m_valid_q || m_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (cmd_hs) begin
                    addr_d   = cmd_base;
                    remain_d = cmd_len;
                    state_d  = RD_RUN;
                end
            end
            RD_RUN: begin
                if (remain_q != '0 && slot_free) begin
                    m_data_d  = rd_data;
                    m_valid_d = 1'b1;
                    m_last_d  = (remain_q == LW'(1));
                    addr_d    = addr_q + AW'(1);
                    remain_d  = remain_q - LW'(1);
                end else if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
                if (remain_q == '0 && slot_free) begin
                    state_d = RD_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RD_IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
        end
    end

    assign rd_addr = addr_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign done    = done_q;

`ifdef RAM_STREAM_READER_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (cmd_hs) begin
            stall_d = '0;
        end else if (m_valid_q && !m_ready && stall_q != '1) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: table of commands plus reset and back-to-back cases.
// Expected stall_cnt follows RAM_STREAM_READER_STALL_CNT_EN.
module tb_ram_stream_reader;

    localparam int DW    = 8;
    localparam int WORDS = 16;
    localparam int AW    = 4;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          done;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    logic [DW-1:0] ram [WORDS];
    assign rd_data = ram[rd_addr];

    ram_stream_reader #(.DW(DW), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        bit            rnd;
        int            done_c;
        logic [DW-1:0] last;
    } vec_t;

    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;

    int            n_beats = 0;
    int            n_last = 0;
    int            stall_seen = 0;
    logic [DW-1:0] last_data = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    beat_t         exp_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within bound", name);
    endtask

    // Stream monitor: pops the scoreboard on each handshake, checks hold-while-stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
                chk("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    exp_b = sb.pop_front();
                    chk("beat_data", 32'(m_data), 32'(exp_b.data));
                    chk("beat_last", 32'(m_last), 32'(exp_b.last));
                end
                n_beats++;
                if (m_last) begin
                    n_last++;
                    last_data = m_data;
                end
            end
            if (m_valid && !m_ready) stall_seen++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_cmd(input logic [AW-1:0] base, input logic [LW-1:0] len);
        beat_t b;
        for (int i = 0; i < int'(len); i++) begin
            b.data = ram[(int'(base) + i) % WORDS];
            b.last = (i == int'(len) - 1);
            sb.push_back(b);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int g = 0; g < 50; g++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) fail_now(name);
    endtask

    task automatic run_cmd(input logic [AW-1:0] base, input logic [LW-1:0] len, input bit rnd,
                           input int exp_done_c);
        int c;
        int done_c;
        wait_idle("run_idle");
        stall_seen = 0;
        n_beats    = 0;
        n_last     = 0;
        cmd_base   = base;
        cmd_len    = len;
        cmd_valid  = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_base  = ~base;
        cmd_len   = 5'd3;
        push_cmd(base, len);
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        chk("rd_addr_start", 32'(rd_addr), 32'(base));
        chk("m_valid_c0", 32'(m_valid), 32'd0);
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        c      = 0;
        done_c = -1;
        while (done_c < 0 && c < 400) begin
            @(posedge clk); #1;
            c++;
            if (c == 1) chk("first_valid", 32'(m_valid), 32'(len != 0));
            if (done) begin
                done_c = c;
                chk("ready_in_done", 32'(cmd_ready), 32'd1);
            end else if (!rnd && c < int'(len)) begin
                chk("rd_addr_seq", 32'(rd_addr), 32'((int'(base) + c) % WORDS));
            end
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        m_ready = 1'b1;
        if (done_c < 0) begin
            fail_now("done_timeout");
        end else begin
            if (exp_done_c > 0) chk("done_cycle", 32'(done_c), 32'(exp_done_c));
            chk("beat_count", 32'(n_beats), 32'(len));
            chk("last_count", 32'(n_last), 32'(len != 0));
            chk("sb_empty", 32'(sb.size()), 32'd0);
            chk("rd_addr_end", 32'(rd_addr), 32'((int'(base) + int'(len)) % WORDS));
            @(posedge clk); #1;
            chk("done_one_cycle", 32'(done), 32'd0);
        end
    endtask

    vec_t vecs[6];
    bit   seen;

    initial begin
        for (int i = 0; i < WORDS; i++) ram[i] = 8'(i);
        vecs[0] = '{base: 4'd3,  len: 5'd4,  rnd: 1'b0, done_c: 5,  last: 8'h06};
        vecs[1] = '{base: 4'd14, len: 5'd4,  rnd: 1'b0, done_c: 5,  last: 8'h01};
        vecs[2] = '{base: 4'd5,  len: 5'd0,  rnd: 1'b0, done_c: 1,  last: 8'h00};
        vecs[3] = '{base: 4'd0,  len: 5'd16, rnd: 1'b1, done_c: 0,  last: 8'h0F};
        vecs[4] = '{base: 4'd15, len: 5'd1,  rnd: 1'b0, done_c: 2,  last: 8'h0F};
        vecs[5] = '{base: 4'd7,  len: 5'd16, rnd: 1'b0, done_c: 17, last: 8'h06};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        m_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            run_cmd(vecs[k].base, vecs[k].len, vecs[k].rnd, vecs[k].done_c);
            if (vecs[k].len != 0) chk("last_data", 32'(last_data), 32'(vecs[k].last));
            if (vecs[k].rnd) begin
`ifdef RAM_STREAM_READER_STALL_CNT_EN
                chk("stall_cnt", 32'(stall_cnt), 32'(stall_seen));
`else
                chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
            end
        end

        // Reset in the middle of a len=8 command.
        wait_idle("rst_idle");
        n_beats   = 0;
        cmd_base  = 4'd0;
        cmd_len   = 5'd8;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        push_cmd(4'd0, 5'd8);
        for (int g = 0; g < 30 && n_beats < 2; g++) begin
            @(posedge clk); #1;
        end
        if (n_beats < 2) fail_now("rst_two_beats");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_m_last", 32'(m_last), 32'd0);
        chk("mid_rst_m_data", 32'(m_data), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        sb.delete();
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            @(posedge clk); #1;
            chk("post_rst_no_done", 32'(done), 32'd0);
            chk("post_rst_no_valid", 32'(m_valid), 32'd0);
        end

        // Back-to-back: second command held valid during the first run.
        wait_idle("b2b_idle");
        n_beats   = 0;
        n_last    = 0;
        cmd_base  = 4'd2;
        cmd_len   = 5'd3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        push_cmd(4'd2, 5'd3);
        cmd_base = 4'd9;
        cmd_len  = 5'd2;
        seen     = 1'b0;
        for (int g = 0; g < 40; g++) begin
            if (cmd_ready) begin
                chk("b2b_accept_in_done", 32'(done), 32'd1);
                chk("b2b_a_drained", 32'(sb.size()), 32'd0);
                chk("b2b_a_beats", 32'(n_beats), 32'd3);
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) fail_now("b2b_ready");
        push_cmd(4'd9, 5'd2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("b2b_second_busy", 32'(cmd_ready), 32'd0);
        seen = 1'b0;
        for (int g = 0; g < 40; g++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("b2b_done");
        chk("b2b_total_beats", 32'(n_beats), 32'd5);
        chk("b2b_last_count", 32'(n_last), 32'd2);
        chk("b2b_last_data", 32'(last_data), 32'h0A);
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
